decode_buffer: RTL and testbench

Parametrised decode stage with elastic buffering, sitting between the fetch stage and the execute stage of the pipelined core. Each accepted instruction is decoded once, on entry, into the pipeline control word. The decoded word is stored together with the instruction and PC in a DEPTH-entry FIFO, which drains to execute under a valid/ready handshake. Optional FPU opcodes (flw/fsw/OP-FP) are decoded when FPU_EN=1. Flush discards all buffered entries on branch/jump redirect.

---
 rtl/decode_buffer.sv | 127 ++++++++++++
 tb/tb_decode_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_buffer.sv
// Decodes fetch instructions on entry and buffers {instr, pc, ctrl} in a DEPTH-entry FIFO toward execute.
// Latency: one cycle from push edge to out_valid; in_ready drops only when full (or in reset).
module decode_buffer #(
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32,
  parameter int FPU_EN = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [13:0]                out_ctrl,
  output logic                       out_fp_write,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     out_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [13:0]     ctrl;
    logic            fp_write;
    logic            illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            push;
  logic            pop;

  // ctrl = {reg_write, imm_src[2:0], alu_src, mem_write, result_src[2:0], branch, alu_op[1:0], jump, c_reg_write}
  always_comb begin
    dec          = '0;
    dec.instr    = in_instr;
    dec.pc       = in_pc;
    dec.illegal  = 1'b0;
    case (in_instr[6:0])
      7'b0000011: dec.ctrl = 14'b1_000_1_0_001_0_00_0_0;
      7'b0100011: dec.ctrl = 14'b0_001_1_1_000_0_00_0_0;
      7'b0010111: dec.ctrl = 14'b1_101_1_0_000_0_11_0_0;
      7'b0110011: dec.ctrl = 14'b1_000_0_0_000_0_10_0_0;
      7'b0110111: dec.ctrl = 14'b1_101_0_0_100_0_00_0_0;
      7'b1100011: dec.ctrl = 14'b0_010_0_0_000_1_01_0_0;
      7'b0010011: begin
        if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
          dec.ctrl = 14'b1_100_1_0_000_0_10_0_0;
        else
          dec.ctrl = 14'b1_000_1_0_000_0_10_0_0;
      end
      7'b1100111: dec.ctrl = 14'b1_000_1_0_010_0_10_1_0;
      7'b1101111: dec.ctrl = 14'b1_011_0_0_010_0_00_1_0;
      7'b1110011: dec.ctrl = 14'b1_000_0_0_011_0_00_0_1;
      7'b0000111: begin
        if (FPU_EN != 0) begin
          dec.ctrl     = 14'b0_000_1_0_001_0_00_0_0;
          dec.fp_write = 1'b1;
        end else begin
          dec.illegal  = 1'b1;
        end
      end
      7'b0100111: begin
        if (FPU_EN != 0) dec.ctrl = 14'b0_001_1_1_000_0_00_0_0;
        else             dec.illegal = 1'b1;
      end
      7'b1010011: begin
        if (FPU_EN != 0) begin
          dec.ctrl     = 14'b0_000_0_0_101_0_00_0_0;
          dec.fp_write = 1'b1;
        end else begin
          dec.illegal  = 1'b1;
        end
      end
      default:    dec.illegal = 1'b1;
    endcase
  end

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = rstn && !full;
  assign out_valid = rstn && (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign out_count = count;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; out_* are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head         = mem[rd_ptr];
  assign out_instr    = out_valid ? head.instr    : '0;
  assign out_pc       = out_valid ? head.pc       : '0;
  assign out_ctrl     = out_valid ? head.ctrl     : '0;
  assign out_fp_write = out_valid ? head.fp_write : 1'b0;
  assign out_illegal  = out_valid ? head.illegal  : 1'b0;

endmodule

// File: tb/tb_decode_buffer.sv
// Scoreboard bench: two instances (FPU_EN=1 and FPU_EN=0) share stimulus and one expected-entry queue.
module tb_decode_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn, in_valid, flush, out_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            rdy_w [2];
  logic            o_valid [2];
  logic [31:0]     o_instr [2];
  logic [XLEN-1:0] o_pc [2];
  logic [13:0]     o_ctrl [2];
  logic            o_fp [2];
  logic            o_ill [2];
  logic [CW-1:0]   o_cnt [2];

  decode_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .FPU_EN(1)) u_fp (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy_w[0]),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_instr(o_instr[0]),
    .out_pc(o_pc[0]), .out_ctrl(o_ctrl[0]), .out_fp_write(o_fp[0]),
    .out_illegal(o_ill[0]), .out_count(o_cnt[0])
  );

  decode_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .FPU_EN(0)) u_nofp (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy_w[1]),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_instr(o_instr[1]),
    .out_pc(o_pc[1]), .out_ctrl(o_ctrl[1]), .out_fp_write(o_fp[1]),
    .out_illegal(o_ill[1]), .out_count(o_cnt[1])
  );

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } txn_t;

  txn_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference decode: returns {illegal, fp_write, ctrl[13:0]}
  function automatic logic [15:0] ref_decode(input logic [31:0] ins, input bit fpu);
    logic [13:0] c;
    logic        fp;
    logic        ill;
    c = '0; fp = 1'b0; ill = 1'b0;
    case (ins[6:0])
      7'h03: c = 14'b1_000_1_0_001_0_00_0_0;
      7'h23: c = 14'b0_001_1_1_000_0_00_0_0;
      7'h17: c = 14'b1_101_1_0_000_0_11_0_0;
      7'h33: c = 14'b1_000_0_0_000_0_10_0_0;
      7'h37: c = 14'b1_101_0_0_100_0_00_0_0;
      7'h63: c = 14'b0_010_0_0_000_1_01_0_0;
      7'h13: c = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 14'b1_100_1_0_000_0_10_0_0
                                                            : 14'b1_000_1_0_000_0_10_0_0;
      7'h67: c = 14'b1_000_1_0_010_0_10_1_0;
      7'h6F: c = 14'b1_011_0_0_010_0_00_1_0;
      7'h73: c = 14'b1_000_0_0_011_0_00_0_1;
      7'h07: if (fpu) begin c = 14'b0_000_1_0_001_0_00_0_0; fp = 1'b1; end else ill = 1'b1;
      7'h27: if (fpu) c = 14'b0_001_1_1_000_0_00_0_0; else ill = 1'b1;
      7'h53: if (fpu) begin c = 14'b0_000_0_0_101_0_00_0_0; fp = 1'b1; end else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    return {ill, fp, c};
  endfunction

  // Monitor: compare both heads against the queue front, then apply this cycle's handshakes.
  logic [15:0] m_dec;
  bit          m_have, m_full;
  always @(negedge clk) begin
    m_have = (sb.size() > 0);
    m_full = (sb.size() >= DEPTH);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid%0d", i), o_valid[i], rstn && m_have);
      check($sformatf("in_ready%0d", i), rdy_w[i], rstn && !m_full);
      if (rstn) check($sformatf("count%0d", i), o_cnt[i], sb.size());
      if (rstn && m_have) begin
        m_dec = ref_decode(sb[0].instr, (i == 0));
        check($sformatf("instr%0d", i), o_instr[i], sb[0].instr);
        check($sformatf("pc%0d", i), o_pc[i], sb[0].pc);
        check($sformatf("ctrl%0d", i), o_ctrl[i], m_dec[13:0]);
        check($sformatf("fp_write%0d", i), o_fp[i], m_dec[14]);
        check($sformatf("illegal%0d", i), o_ill[i], m_dec[15]);
      end else begin
        check($sformatf("idle_ipc%0d", i), {o_instr[i], o_pc[i]}, 64'd0);
        check($sformatf("idle_ctl%0d", i), {o_ctrl[i], o_fp[i], o_ill[i]}, 64'd0);
      end
    end
    if (!rstn || flush) begin
      sb.delete();
    end else begin
      if (m_have && out_ready) void'(sb.pop_front());
      if (in_valid && !m_full) sb.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ops [16];

  task automatic drive_op(input int k);
    in_instr = ($urandom & ~32'h0000707F) | (ops[k] & 32'h0000707F);
    in_pc    = $urandom & 32'hFFFF_FFFC;
  endtask

  initial begin
    ops[0]  = 32'h0000_0003; ops[1]  = 32'h0000_0023; ops[2]  = 32'h0000_0017;
    ops[3]  = 32'h0000_0033; ops[4]  = 32'h0000_0037; ops[5]  = 32'h0000_0063;
    ops[6]  = 32'h0000_1013; ops[7]  = 32'h0000_5013; ops[8]  = 32'h0000_2013;
    ops[9]  = 32'h0000_0067; ops[10] = 32'h0000_006F; ops[11] = 32'h0000_1073;
    ops[12] = 32'h0000_0007; ops[13] = 32'h0000_0027; ops[14] = 32'h0000_0053;
    ops[15] = 32'h0000_007F;

    rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) step();
    check("reset_count", o_cnt[0], 0);
    rstn = 1'b1;
    step();

    // First transaction latency
    in_valid = 1'b1; in_instr = 32'h0001_2083; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    check("lw_valid", o_valid[0], 1);
    check("lw_ctrl", o_ctrl[0], 14'b1_000_1_0_001_0_00_0_0);
    check("lw_pc", o_pc[0], 32'h100);
    check("lw_illegal", o_ill[0], 0);
    out_ready = 1'b1;
    step();

    // Opcode sweep, one per cycle
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      drive_op(k);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Fill to full, extra push blocked
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive_op(k);
      step();
    end
    check("full_count", o_cnt[0], DEPTH);
    check("full_ready", rdy_w[0], 0);
    out_ready = 1'b1;
    drive_op(9);
    step();
    check("full_pop_only", o_cnt[0], DEPTH - 1);
    drive_op(10);
    step();
    check("push_pop_count", o_cnt[0], DEPTH - 1);
    in_valid = 1'b0;
    repeat (DEPTH + 1) step();
    check("drained", o_cnt[0], 0);

    // Flush with two buffered entries
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin drive_op(3); step(); end
    check("pre_flush_count", o_cnt[0], 2);
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", o_cnt[0], 0);
    check("flush_valid", o_valid[0], 0);

    // Reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin drive_op(5); step(); end
    in_valid = 1'b0; rstn = 1'b0;
    #1;
    check("rst_valid", o_valid[0], 0);
    check("rst_ready", rdy_w[0], 0);
    step();
    rstn = 1'b1;
    check("rst_count", o_cnt[0], 0);
    step();

    // Random traffic
    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      drive_op($urandom_range(0, 15));
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    check("final_empty", o_cnt[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
